// File: rtl/seven_segment_capture.sv
// Seven-segment bus capture: debounces each digit dwell, decodes the
// hex font and hands complete frames out over valid/ready.
module seven_segment_capture #(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [6:0]            segments,
  input  logic [DIGITS-1:0]     digit_select,
  input  logic                  frame_ready,
  output logic                  frame_valid,
  output logic [4*DIGITS-1:0]   frame_data,
  output logic [DIGITS-1:0]     frame_error,
  output logic                  overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  typedef enum logic {COLLECT, HOLD} state_e;

  logic [6:0]          seg_q, seg_prev_q;
  logic [DIGITS-1:0]   sel_q, sel_prev_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] wdata_q, wdata_d;
  logic [DIGITS-1:0]   werr_q, werr_d;
  state_e              state_q;
  logic [4*DIGITS-1:0] fdata_q;
  logic [DIGITS-1:0]   ferr_q;
  logic                ovr_q;

  logic       onehot, changed, capture, complete;
  logic [3:0] nib;
  logic       bad;

  assign onehot  = (sel_q != '0) &&
                   ((sel_q & (sel_q - DIGITS'(1))) == '0);
  assign changed = {sel_q, seg_q} != {sel_prev_q, seg_prev_q};

  always_comb begin
    cnt_d = cnt_q;
    if (changed || !onehot)
      cnt_d = CW'(1);
    else if (cnt_q != CMAX)
      cnt_d = cnt_q + CW'(1);
  end

  // Capture only on the transition into saturation, once per dwell.
  assign capture = (cnt_d == CMAX) && (cnt_q != CMAX);

  always_comb begin
    nib = 4'h0;
    bad = 1'b0;
    case (seg_q)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    wdata_d  = wdata_q;
    werr_d   = werr_q;
    seen_d   = seen_q;
    complete = 1'b0;
    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (sel_q[i]) begin
          wdata_d[4*i +: 4] = nib;
          werr_d[i]         = bad;
        end
      end
      seen_d = seen_q | sel_q;
      if (seen_d == '1) begin
        complete = 1'b1;
        seen_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q      <= '0;
      sel_q      <= '0;
      seg_prev_q <= '0;
      sel_prev_q <= '0;
      cnt_q      <= '0;
      seen_q     <= '0;
      wdata_q    <= '0;
      werr_q     <= '0;
    end else begin
      seg_q      <= SEG_ACTIVE_LOW ? ~segments : segments;
      sel_q      <= digit_select;
      seg_prev_q <= seg_q;
      sel_prev_q <= sel_q;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      wdata_q    <= wdata_d;
      werr_q     <= werr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT;
      fdata_q <= '0;
      ferr_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      unique case (state_q)
        COLLECT: begin
          if (complete) begin
            fdata_q <= wdata_d;
            ferr_q  <= werr_d;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (complete) begin
            if (frame_ready) begin
              fdata_q <= wdata_d;
              ferr_q  <= werr_d;
            end else begin
              ovr_q <= 1'b1;
            end
          end else if (frame_ready) begin
            state_q <= COLLECT;
          end
        end
      endcase
    end
  end

  assign frame_valid = (state_q == HOLD);
  assign frame_data  = fdata_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Bench for seven_segment_capture: directed scans, scoreboard
// checked by a monitor on each accepted frame.
module tb_seven_segment_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  segments;
  logic [3:0]  digit_select;
  logic        frame_ready;
  logic        frame_valid;
  logic [15:0] frame_data;
  logic [3:0]  frame_error;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  logic [19:0] sb[$];

  seven_segment_capture #(
    .DIGITS(4),
    .STABLE_CYCLES(4),
    .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .segments(segments),
    .digit_select(digit_select),
    .frame_ready(frame_ready),
    .frame_valid(frame_valid),
    .frame_data(frame_data),
    .frame_error(frame_error),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic show(input logic [3:0] sel, input logic [6:0] seg,
                      input int n);
    digit_select = sel;
    segments     = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                      input logic [6:0] p2, input logic [6:0] p3);
    show(4'b0001, p0, 8);
    show(4'b0010, p1, 8);
    show(4'b0100, p2, 8);
    show(4'b1000, p3, 8);
    show(4'b0000, 7'h00, 4);
  endtask

  // Monitor: samples mid low phase, pops on every accepted frame.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n) begin
        if (overrun) ovr_cnt++;
        if (frame_valid && frame_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %h/%b expected none",
                     frame_data, frame_error);
          end else begin
            e = sb.pop_front();
            chk("frame_data", 32'(frame_data), 32'(e[19:4]));
            chk("frame_error", 32'(frame_error), 32'(e[3:0]));
          end
        end
      end
    end
  end

  initial begin
    reset_n      = 1'b0;
    frame_ready  = 1'b0;
    segments     = '0;
    digit_select = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_valid", 32'(frame_valid), 0);
    chk("rst_data", 32'(frame_data), 0);
    chk("rst_error", 32'(frame_error), 0);
    chk("rst_overrun", 32'(overrun), 0);
    @(negedge clk);
    reset_n     = 1'b1;
    frame_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Basic scan 0,1,2,3
    sb.push_back({16'h3210, 4'b0000});
    scan(7'h3F, 7'h06, 7'h5B, 7'h4F);

    // Short dwell on digit 2 must not capture
    sb.push_back({16'h8B54, 4'b0000});
    show(4'b0001, 7'h66, 8);
    show(4'b0010, 7'h6D, 8);
    show(4'b1000, 7'h7F, 8);
    show(4'b0100, 7'h39, 3);
    show(4'b0000, 7'h00, 6);
    #2;
    chk("short_dwell_no_frame", 32'(frame_valid), 0);
    @(negedge clk);
    show(4'b0100, 7'h7C, 8);
    show(4'b0000, 7'h00, 4);

    // Non-font pattern on digit 1 after a one-sample glitch
    sb.push_back({16'h3200, 4'b0010});
    show(4'b0001, 7'h3F, 8);
    show(4'b0010, 7'h7F, 1);
    show(4'b0010, 7'h49, 8);
    show(4'b0100, 7'h5B, 8);
    show(4'b1000, 7'h4F, 8);
    show(4'b0000, 7'h00, 4);

    // Backpressure: second frame dropped with one overrun pulse
    frame_ready = 1'b0;
    sb.push_back({16'hDCBA, 4'b0000});
    scan(7'h77, 7'h7C, 7'h39, 7'h5E);
    scan(7'h79, 7'h71, 7'h3F, 7'h06);
    #2;
    chk("held_valid", 32'(frame_valid), 1);
    chk("held_data", 32'(frame_data), 32'h0000_DCBA);
    chk("overrun_count", 32'(ovr_cnt), 1);
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    #2;
    chk("valid_drops", 32'(frame_valid), 0);
    @(negedge clk);

    // Multi-hot and blank select never capture
    sb.push_back({16'h2109, 4'b0000});
    show(4'b0001, 7'h6F, 8);
    show(4'b0010, 7'h3F, 8);
    show(4'b0100, 7'h06, 8);
    show(4'b0110, 7'h7D, 10);
    show(4'b0000, 7'h7D, 6);
    #2;
    chk("multihot_no_frame", 32'(frame_valid), 0);
    @(negedge clk);
    show(4'b1000, 7'h5B, 8);
    show(4'b0000, 7'h00, 4);

    // Reset mid-frame with a pending frame held
    frame_ready = 1'b0;
    scan(7'h06, 7'h06, 7'h06, 7'h06);
    show(4'b0001, 7'h07, 8);
    show(4'b0010, 7'h07, 8);
    show(4'b0100, 7'h07, 8);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_valid", 32'(frame_valid), 0);
    chk("mid_rst_data", 32'(frame_data), 0);
    chk("mid_rst_error", 32'(frame_error), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    @(negedge clk);
    show(4'b0000, 7'h00, 1);
    reset_n     = 1'b1;
    frame_ready = 1'b1;
    show(4'b0000, 7'h00, 2);
    sb.push_back({16'h6543, 4'b0000});
    show(4'b1000, 7'h7D, 8);
    show(4'b0000, 7'h00, 4);
    #2;
    chk("post_rst_partial", 32'(frame_valid), 0);
    @(negedge clk);
    show(4'b0001, 7'h4F, 8);
    show(4'b0010, 7'h66, 8);
    show(4'b0100, 7'h6D, 8);
    show(4'b0000, 7'h00, 6);

    #2;
    chk("scoreboard_empty", 32'(sb.size()), 0);
    chk("overrun_total", 32'(ovr_cnt), 1);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
